// File: rtl/raptor64_bht_ctrl_if.sv
// Purpose: bundles the BHT controller's update, flush, table-port and status signals.
// Latency: none (wires only); the controller drives table writes combinationally.
// Backpressure: none; updates arriving during a clear are dropped by the controller.
//
// Port summary:
//   flush_req               request a full-table clear
//   upd_valid/addr/bits     EX-stage counter update
//   bht_ra / bht_rd         aging read port (combinational read data)
//   bht_we / bht_wa / bht_wd  single table write port
//   busy / predict_en / hist_clr  clear status toward the IF stage
interface raptor64_bht_ctrl_if #(
    parameter int unsigned ENTRIES_LOG2 = 8
);
    logic                    flush_req;
    logic                    upd_valid;
    logic [ENTRIES_LOG2-1:0] upd_addr;
    logic [1:0]              upd_bits;
    logic [ENTRIES_LOG2-1:0] bht_ra;
    logic [1:0]              bht_rd;
    logic                    bht_we;
    logic [ENTRIES_LOG2-1:0] bht_wa;
    logic [1:0]              bht_wd;
    logic                    busy;
    logic                    predict_en;
    logic                    hist_clr;

    // Controller side: owns the table write port and the status outputs.
    modport master (
        input  flush_req,
        input  upd_valid,
        input  upd_addr,
        input  upd_bits,
        input  bht_rd,
        output bht_ra,
        output bht_we,
        output bht_wa,
        output bht_wd,
        output busy,
        output predict_en,
        output hist_clr
    );

    // Pipeline/table side: issues updates and flushes, serves the aging read.
    modport slave (
        output flush_req,
        output upd_valid,
        output upd_addr,
        output upd_bits,
        output bht_rd,
        input  bht_ra,
        input  bht_we,
        input  bht_wa,
        input  bht_wd,
        input  busy,
        input  predict_en,
        input  hist_clr
    );
endinterface

// File: rtl/raptor64_bht_ctrl.sv
// Purpose: sole writer of the 2-bit BHT: clear sweep, EX updates, background aging.
// Latency: writes are combinational from state/inputs (0 cycles); clear takes 2^ENTRIES_LOG2 cycles.
// Backpressure: none; updates during a clear are dropped, aging waits for a free write port.
//
// Ports: clk, rst (synchronous, active-high), bus (raptor64_bht_ctrl_if.master).
// Counter encoding: 0 strong taken, 1 weak taken, 2 strong not-taken, 3 weak not-taken.
module raptor64_bht_ctrl #(
    parameter int unsigned ENTRIES_LOG2 = 8,
    parameter logic [1:0]  INIT_VAL     = 2'd3,
    parameter logic [15:0] AGE_PERIOD   = 16'd1024
) (
    input  logic                       clk,
    input  logic                       rst,
    raptor64_bht_ctrl_if.master        bus
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam logic [ENTRIES_LOG2-1:0] LAST_ADDR  = '1;
    localparam logic [ENTRIES_LOG2-1:0] ADDR_ONE   = {{(ENTRIES_LOG2-1){1'b0}}, 1'b1};
    localparam bit                      AGE_ENABLE = (AGE_PERIOD != 16'd0);
    localparam logic [15:0]             AGE_LAST   = AGE_PERIOD - 16'd1;

    state_t                  state, state_nxt;
    logic [ENTRIES_LOG2-1:0] clr_addr, clr_addr_nxt;
    logic [ENTRIES_LOG2-1:0] age_ptr, age_ptr_nxt;
    logic [15:0]             age_cnt, age_cnt_nxt;
    logic                    age_pending, age_pending_nxt;

    logic                    age_expire;
    logic [1:0]              aged_bits;
    logic                    we;
    logic [ENTRIES_LOG2-1:0] wa;
    logic [1:0]              wd;
    logic                    busy;

    // A period boundary only exists while aging is enabled and we are idle.
    assign age_expire = AGE_ENABLE && (state == ST_IDLE) && (age_cnt == AGE_LAST);

    // Strong states relax to their weak neighbour; weak states are rewritten as-is.
    always_comb begin
        aged_bits = bus.bht_rd;
        if (bus.bht_rd == 2'd0) begin
            aged_bits = 2'd1;
        end else if (bus.bht_rd == 2'd2) begin
            aged_bits = 2'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        clr_addr_nxt    = clr_addr;
        age_ptr_nxt     = age_ptr;
        age_cnt_nxt     = age_cnt;
        age_pending_nxt = age_pending;
        we              = 1'b0;
        wa              = clr_addr;
        wd              = INIT_VAL;
        busy            = 1'b1;

        case (state)
            ST_CLEAR: begin
                we              = 1'b1;
                wa              = clr_addr;
                wd              = INIT_VAL;
                age_cnt_nxt     = 16'd0;
                age_pending_nxt = 1'b0;
                if (bus.flush_req) begin
                    clr_addr_nxt = '0;
                end else if (clr_addr == LAST_ADDR) begin
                    clr_addr_nxt = '0;
                    state_nxt    = ST_IDLE;
                end else begin
                    clr_addr_nxt = clr_addr + ADDR_ONE;
                end
            end

            ST_IDLE: begin
                busy = 1'b0;
                if (!AGE_ENABLE || age_expire) begin
                    age_cnt_nxt = 16'd0;
                end else begin
                    age_cnt_nxt = age_cnt + 16'd1;
                end

                if (bus.flush_req) begin
                    // The request cycle itself writes nothing.
                    state_nxt       = ST_CLEAR;
                    clr_addr_nxt    = '0;
                    age_cnt_nxt     = 16'd0;
                    age_pending_nxt = 1'b0;
                end else if (bus.upd_valid) begin
                    we = 1'b1;
                    wa = bus.upd_addr;
                    wd = bus.upd_bits;
                    // An expiry that loses arbitration is remembered; repeats collapse.
                    age_pending_nxt = age_pending | age_expire;
                end else if (age_pending || age_expire) begin
                    we              = 1'b1;
                    wa              = age_ptr;
                    wd              = aged_bits;
                    age_ptr_nxt     = age_ptr + ADDR_ONE;
                    age_pending_nxt = 1'b0;
                end
            end

            default: begin
                state_nxt = ST_CLEAR;
            end
        endcase

        // Reset cycle looks like a clear in progress but must not write.
        if (rst) begin
            we   = 1'b0;
            busy = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_addr    <= '0;
            age_ptr     <= '0;
            age_cnt     <= 16'd0;
            age_pending <= 1'b0;
        end else begin
            clr_addr    <= clr_addr_nxt;
            age_ptr     <= age_ptr_nxt;
            age_cnt     <= age_cnt_nxt;
            age_pending <= age_pending_nxt;
        end
    end

    assign bus.bht_ra     = age_ptr;
    assign bus.bht_we     = we;
    assign bus.bht_wa     = wa;
    assign bus.bht_wd     = wd;
    assign bus.busy       = busy;
    assign bus.hist_clr   = busy;
    assign bus.predict_en = ~busy;

endmodule

// File: tb/tb_raptor64_bht_ctrl.sv
// Purpose: self-checking bench for raptor64_bht_ctrl with a behavioural table model.
// Latency: checks combinational write outputs in the same cycle as the driving inputs.
// Backpressure: none modelled; the bench plays both the EX stage and the BHT storage.
module tb_raptor64_bht_ctrl;

    localparam int P     = 4;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    raptor64_bht_ctrl_if #(.ENTRIES_LOG2(8)) bus ();

    raptor64_bht_ctrl #(
        .ENTRIES_LOG2(8),
        .INIT_VAL    (2'd3),
        .AGE_PERIOD  (16'd4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Table storage served by the bench.
    logic [1:0] mem [DEPTH];
    assign bus.bht_rd = mem[bus.bht_ra];
    always @(posedge clk) begin
        if (bus.bht_we) mem[bus.bht_wa] <= bus.bht_wd;
    end

    // Reference model state, kept as plain counters.
    bit         m_clearing;
    int         m_idx;
    int         m_idle;
    bit         m_owed;
    int         m_ptr;
    logic [1:0] ref_mem [DEPTH];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [1:0] relax(input logic [1:0] v);
        case (v)
            2'd0:    return 2'd1;   // strong taken -> weak taken
            2'd2:    return 2'd3;   // strong not-taken -> weak not-taken
            default: return v;
        endcase
    endfunction

    // One clock: drive at negedge, compare before the next posedge, advance the model.
    task automatic step(input bit r, input bit f, input bit u,
                        input logic [7:0] a, input logic [1:0] b);
        bit         e_we, e_busy, expire;
        int         e_wa;
        logic [1:0] e_wd;
        @(negedge clk);
        rst           = r;
        bus.flush_req = f;
        bus.upd_valid = u;
        bus.upd_addr  = a;
        bus.upd_bits  = b;
        #1;
        cyc++;
        e_we   = 1'b0;
        e_wa   = 0;
        e_wd   = 2'd0;
        expire = ((m_idle + 1) % P) == 0;
        if (r) begin
            e_busy = 1'b1;
        end else if (m_clearing) begin
            e_busy = 1'b1; e_we = 1'b1; e_wa = m_idx; e_wd = 2'd3;
        end else begin
            e_busy = 1'b0;
            if (f) begin
                e_we = 1'b0;
            end else if (u) begin
                e_we = 1'b1; e_wa = a; e_wd = b;
            end else if (m_owed || expire) begin
                e_we = 1'b1; e_wa = m_ptr; e_wd = relax(ref_mem[m_ptr]);
            end
        end
        chk("busy", int'(bus.busy), int'(e_busy));
        chk("hist_clr", int'(bus.hist_clr), int'(e_busy));
        chk("predict_en", int'(bus.predict_en), int'(!e_busy));
        chk("we", int'(bus.bht_we), int'(e_we));
        if (e_we) begin
            chk("wa", int'(bus.bht_wa), e_wa);
            chk("wd", int'(bus.bht_wd), int'(e_wd));
        end
        if (!r) chk("ra", int'(bus.bht_ra), m_ptr);

        if (e_we) ref_mem[e_wa] = e_wd;
        if (r) begin
            m_clearing = 1'b1; m_idx = 0; m_idle = 0; m_owed = 1'b0; m_ptr = 0;
        end else if (m_clearing) begin
            if (f) m_idx = 0;
            else if (m_idx == DEPTH - 1) begin m_clearing = 1'b0; m_idle = 0; end
            else m_idx++;
        end else if (f) begin
            m_clearing = 1'b1; m_idx = 0; m_idle = 0; m_owed = 1'b0;
        end else begin
            m_idle++;
            if (u) m_owed = m_owed | expire;
            else if (m_owed || expire) begin
                m_ptr  = (m_ptr + 1) % DEPTH;
                m_owed = 1'b0;
            end
        end
    endtask

    // Counts writes of a sweep until the controller goes idle; bounded.
    task automatic run_sweep(input string name);
        int writes = 0;
        int first  = -1;
        for (int i = 0; i < 400; i++) begin
            step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 2'($urandom));
            if (!bus.busy) break;
            if (bus.bht_we) begin
                if (first < 0) first = int'(bus.bht_wa);
                writes++;
            end
        end
        chk({name, "_writes"}, writes, DEPTH);
        chk({name, "_first"}, first, 0);
        chk({name, "_idle"}, int'(bus.predict_en), 1);
    endtask

    typedef struct {
        bit         f;
        bit         u;
        logic [7:0] a;
        logic [1:0] b;
        bit         we;
        logic [7:0] wa;
        logic [1:0] wd;
        bit         busy;
    } vec_t;

    vec_t tbl [18];

    initial begin
        int bad;
        // Cycle 0 is the first IDLE cycle after the power-up sweep (AGE_PERIOD=4).
        tbl[0]  = '{1'b0, 1'b1, 8'h00, 2'd0, 1'b1, 8'h00, 2'd0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 8'h01, 2'd2, 1'b1, 8'h01, 2'd2, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 8'h45, 2'd0, 1'b1, 8'h45, 2'd0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 8'h00, 2'd1, 1'b0}; // age entry 0: 0 -> 1
        tbl[4]  = '{1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 2'd0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 2'd0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 2'd0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 8'h01, 2'd3, 1'b0}; // age entry 1: 2 -> 3
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 2'd0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 8'h80, 2'd1, 1'b1, 8'h80, 2'd1, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 8'h81, 2'd0, 1'b1, 8'h81, 2'd0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 8'h82, 2'd3, 1'b1, 8'h82, 2'd3, 1'b0}; // period expires here
        tbl[12] = '{1'b0, 1'b1, 8'h83, 2'd2, 1'b1, 8'h83, 2'd2, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 8'h84, 2'd1, 1'b1, 8'h84, 2'd1, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 8'h02, 2'd3, 1'b0}; // deferred step
        tbl[15] = '{1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 8'h03, 2'd3, 1'b0};
        tbl[16] = '{1'b1, 1'b1, 8'h20, 2'd0, 1'b0, 8'h00, 2'd0, 1'b0}; // flush beats update
        tbl[17] = '{1'b0, 1'b1, 8'h10, 2'd0, 1'b1, 8'h00, 2'd3, 1'b1}; // clear ignores update

        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = 2'd0;
            ref_mem[i] = 2'd0;
        end
        m_clearing    = 1'b1;
        m_idx         = 0;
        m_idle        = 0;
        m_owed        = 1'b0;
        m_ptr         = 0;
        bus.flush_req = 1'b0;
        bus.upd_valid = 1'b0;
        bus.upd_addr  = 8'h00;
        bus.upd_bits  = 2'd0;

        // Reset for two cycles.
        step(1'b1, 1'b0, 1'b0, 8'h00, 2'd0);
        step(1'b1, 1'b0, 1'b1, 8'h10, 2'd0);
        chk("rst_we", int'(bus.bht_we), 0);
        chk("rst_predict_en", int'(bus.predict_en), 0);

        // Power-up sweep: 256 writes of 3, an update to 0x10 mid-sweep is dropped.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b0, i == 16, 8'h10, 2'd0);
            chk("sweep_wa", int'(bus.bht_wa), i);
            chk("sweep_wd", int'(bus.bht_wd), 3);
        end
        chk("dropped_upd", int'(mem[8'h10]), 3);

        // Directed IDLE vectors.
        for (int i = 0; i < 18; i++) begin
            step(1'b0, tbl[i].f, tbl[i].u, tbl[i].a, tbl[i].b);
            chk("tbl_we", int'(bus.bht_we), int'(tbl[i].we));
            chk("tbl_busy", int'(bus.busy), int'(tbl[i].busy));
            if (tbl[i].we) begin
                chk("tbl_wa", int'(bus.bht_wa), int'(tbl[i].wa));
                chk("tbl_wd", int'(bus.bht_wd), int'(tbl[i].wd));
            end
        end

        // Second flush at clr_addr=100 restarts the sweep.
        for (int i = 1; i < 100; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 2'd0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 2'd0);
        chk("reflush_wa", int'(bus.bht_wa), 100);
        run_sweep("reflush");
        chk("clear_kept_0x10", int'(mem[8'h10]), 3);

        // Reset at clr_addr=200 restarts the sweep after deassertion.
        step(1'b0, 1'b1, 1'b0, 8'h00, 2'd0);
        for (int i = 0; i < 200; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 2'd0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 2'd0);
        chk("midrst_we", int'(bus.bht_we), 0);
        run_sweep("midrst");

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 999) == 0, $urandom_range(0, 299) == 0,
                 $urandom_range(0, 2) != 0, 8'($urandom), 2'($urandom));
        end

        @(negedge clk);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i] !== ref_mem[i]) bad++;
        end
        chk("table_contents", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
